// File: rtl/packet_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter with valid/ready ingress.
// Frames chain back-to-back when the FIFO has data at the end of a stop bit.
module packet_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [7:0]                    packet_byte,
  input  logic                          packet_valid,
  output logic                          packet_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   bytes_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [15:0]   CNT_MAX  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, fifo_empty, can_pop, bit_end;

  tx_state_t     state, state_next;
  logic [15:0]   baud_cnt, cnt_next;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_next, sent_inc;

  assign packet_ready = enable && (fifo_level != FULL_LVL);
  assign push         = packet_valid && packet_ready;
  assign fifo_empty   = (fifo_level == {LW{1'b0}});
  assign can_pop      = enable && !fifo_empty;
  assign bit_end      = (baud_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packet_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // State register together with the registered line, busy flag and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TX_IDLE;
      baud_cnt   <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'd0;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      bytes_sent <= 16'd0;
    end else begin
      state      <= state_next;
      baud_cnt   <= cnt_next;
      bit_idx    <= idx_next;
      shift_reg  <= shift_next;
      tx_serial  <= tx_next;
      tx_busy    <= (state_next != TX_IDLE);
      bytes_sent <= bytes_sent + {15'd0, sent_inc};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  state_next = can_pop ? TX_START : TX_IDLE;
      TX_START: state_next = bit_end ? TX_DATA : TX_START;
      TX_DATA:  state_next = (bit_end && bit_idx == 3'd7) ? TX_STOP : TX_DATA;
      TX_STOP:  begin
        if (bit_end) state_next = can_pop ? TX_START : TX_IDLE;
        else         state_next = TX_STOP;
      end
      default:  state_next = TX_IDLE;
    endcase
  end

  // Pop, shift and line values; a stop-bit end with data waiting reloads straight into a start bit
  always_comb begin
    pop        = 1'b0;
    sent_inc   = 1'b0;
    cnt_next   = bit_end ? 16'd0 : baud_cnt + 16'd1;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = tx_serial;
    case (state)
      TX_IDLE: begin
        cnt_next = 16'd0;
        if (can_pop) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          idx_next   = 3'd0;
          tx_next    = 1'b0;
        end else begin
          tx_next    = 1'b1;
        end
      end
      TX_START: begin
        if (bit_end) tx_next = shift_reg[0];
        else         tx_next = 1'b0;
      end
      TX_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          tx_next = 1'b1;
        end else if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          tx_next    = shift_reg[1];
          idx_next   = bit_idx + 3'd1;
        end else begin
          tx_next    = tx_serial;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          sent_inc = 1'b1;
          if (can_pop) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            idx_next   = 3'd0;
            tx_next    = 1'b0;
          end else begin
            tx_next    = 1'b1;
          end
        end else begin
          tx_next = 1'b1;
        end
      end
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_packet_uart_tx.sv
// Randomised and directed bench for packet_uart_tx against a frame-timeline model
// (byte queue plus "cycles into current frame"), with literal pins for the model.
module tb_packet_uart_tx;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  packet_byte = 8'd0;
  logic        packet_valid = 1'b0;
  logic        packet_ready, tx_serial, tx_busy;
  logic [4:0]  fifo_level;
  logic [15:0] bytes_sent;

  packet_uart_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .packet_byte(packet_byte),
    .packet_valid(packet_valid), .packet_ready(packet_ready), .tx_serial(tx_serial),
    .tx_busy(tx_busy), .fifo_level(fifo_level), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: pending bytes, and position inside the frame being sent
  logic [7:0]  mq[$];
  bit          m_active;
  int          m_pos;
  logic [7:0]  m_byte;
  logic [15:0] m_sent;

  logic        tr_line[$];
  logic        tr_busy[$];
  logic [15:0] tr_sent[$];

  logic [7:0] pkt [9] = '{8'h7E, 8'h01, 8'h09, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hE0, 8'h7E};
  bit saw_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_byte   = 8'd0;
    m_sent   = 16'd0;
  endtask

  function automatic logic exp_line();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / N;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_edge(input logic e, input logic v, input logic [7:0] d, input logic rdy);
    bit fend;
    fend = m_active && (m_pos == FRAME - 1);
    if (fend) m_sent = m_sent + 16'd1;
    if ((!m_active || fend) && e && mq.size() > 0) begin
      m_byte   = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else if (fend) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_pos++;
    end
    if (v && rdy) mq.push_back(d);
  endtask

  task automatic step(input logic e, input logic v, input logic [7:0] d, output logic acc);
    logic rdy;
    enable = e; packet_valid = v; packet_byte = d;
    #1;
    rdy = e && (mq.size() != DEPTH);
    chk("packet_ready", packet_ready, rdy);
    acc = v && rdy;
    @(posedge clk);
    model_edge(e, v, d, rdy);
    #1;
    chk("tx_serial", tx_serial, exp_line());
    chk("tx_busy", tx_busy, m_active);
    chk("fifo_level", fifo_level, mq.size());
    chk("bytes_sent", bytes_sent, m_sent);
    if (fifo_level == 5'd16) saw_full = 1'b1;
    tr_line.push_back(tx_serial);
    tr_busy.push_back(tx_busy);
    tr_sent.push_back(bytes_sent);
  endtask

  task automatic idle(input logic e, input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) step(e, 1'b0, 8'h00, acc);
  endtask

  task automatic clear_trace();
    tr_line.delete(); tr_busy.delete(); tr_sent.delete();
  endtask

  initial begin
    logic acc;
    logic [9:0]  exp_a5;
    logic [7:0]  dec;
    logic [15:0] s0;
    int f, n, guard;

    model_reset();
    saw_full = 1'b0;
    // Reset held 5 cycles with enable high
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx_serial", tx_serial, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_fifo_level", fifo_level, 5'd0);
    chk("rst_bytes_sent", bytes_sent, 16'd0);
    chk("rst_packet_ready", packet_ready, 1'b1);
    rst = 1'b0;

    // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1, four cycles each
    exp_a5 = 10'b1101001010;
    clear_trace();
    step(1'b1, 1'b1, 8'hA5, acc);
    idle(1'b1, 44);
    chk("a5_before_fall", tr_line[0], 1'b1);
    for (int j = 0; j < 10; j++)
      for (int c = 0; c < N; c++)
        chk("a5_bit", tr_line[1 + N*j + c], exp_a5[j]);
    chk("a5_idle_after", tr_line[41], 1'b1);
    chk("a5_busy_last", tr_busy[40], 1'b1);
    chk("a5_busy_done", tr_busy[41], 1'b0);
    chk("a5_sent_before", tr_sent[40], 16'd0);
    chk("a5_sent_after", tr_sent[41], 16'd1);

    // Nine-byte packet back-to-back, decoded from the line
    clear_trace();
    s0 = bytes_sent;
    for (int b = 0; b < 9; b++) step(1'b1, 1'b1, pkt[b], acc);
    idle(1'b1, 9 * FRAME + 10);
    f = -1;
    for (int i = 0; i < tr_line.size() && f < 0; i++) if (tr_line[i] == 1'b0) f = i;
    chk("pkt_fall_index", f, 1);
    if (f >= 0) begin
      for (int b = 0; b < 9; b++) begin
        chk("pkt_start", tr_line[f + b*FRAME + 2], 1'b0);
        for (int i = 0; i < 8; i++) dec[i] = tr_line[f + b*FRAME + N*(i+1) + 2];
        chk("pkt_byte", dec, pkt[b]);
        chk("pkt_stop", tr_line[f + b*FRAME + 9*N + 2], 1'b1);
      end
      chk("pkt_busy_span", tr_busy[f + 9*FRAME - 1], 1'b1);
      chk("pkt_idle_end", tr_busy[f + 9*FRAME], 1'b0);
    end
    chk("pkt_sent", bytes_sent - s0, 16'd9);

    // Backpressure: valid held high with incrementing data until 30 accepted
    n = 0; guard = 0;
    while (n < 30 && guard < 3000) begin
      step(1'b1, 1'b1, 8'(n), acc);
      if (acc) n++;
      guard++;
    end
    chk("bp_accepted_30", n, 30);
    chk("bp_reached_full", saw_full, 1'b1);
    idle(1'b1, DEPTH * FRAME + 50);
    chk("bp_drained", fifo_level, 5'd0);

    // Enable drop mid-frame with 3 bytes queued
    s0 = bytes_sent;
    for (int b = 0; b < 4; b++) step(1'b1, 1'b1, 8'hC0 + 8'(b), acc);
    idle(1'b1, 15);
    idle(1'b0, FRAME);
    chk("en_busy", tx_busy, 1'b0);
    chk("en_level", fifo_level, 5'd3);
    chk("en_ready", packet_ready, 1'b0);
    chk("en_sent", bytes_sent - s0, 16'd1);
    idle(1'b1, 3 * FRAME + 5);
    chk("en_resume_level", fifo_level, 5'd0);
    chk("en_resume_sent", bytes_sent - s0, 16'd4);

    // Randomised traffic with sporadic enable drops, then drain
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) < 2), 8'($urandom), acc);
    idle(1'b1, DEPTH * FRAME + 50);

    // Reset mid-frame with 5 bytes queued: asynchronous abort
    for (int b = 0; b < 6; b++) step(1'b1, 1'b1, 8'($urandom), acc);
    idle(1'b1, 12);
    chk("mr_in_frame", tx_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mr_tx_serial", tx_serial, 1'b1);
    chk("mr_fifo_level", fifo_level, 5'd0);
    chk("mr_tx_busy", tx_busy, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_trace();
    idle(1'b1, 60);
    f = 0;
    for (int i = 0; i < tr_line.size(); i++) if (tr_line[i] != 1'b1) f++;
    chk("mr_no_residual", f, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
